// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: drives datapath selects/enables across fetch..writeback.
// Optional MC_SLT_EN macro enables slt decode (funct3 010 -> ALUControl 101).
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StError    = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic       pc_update, branch, mem_write, ir_write, reg_write, done;
    logic [1:0] alu_op;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFetch;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        unique case (state_q)
            StFetch: begin
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b10;
                ir_write  = mem_ready;
                pc_update = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b1100011:             state_d = StBeq;
                    7'b1101111:             state_d = StJal;
                    default:                state_d = StError;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == 7'b0000011) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                done      = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                done    = 1'b1;
                state_d = StFetch;
            end
            StError: state_d = StError;
            default: state_d = StFetch;
        endcase
    end

    // Write enables are held off for the whole reset window, not just from the next edge.
    assign PCWrite    = ~rst & (pc_update | (branch & zero));
    assign MemWrite   = ~rst & mem_write;
    assign IRWrite    = ~rst & ir_write;
    assign RegWrite   = ~rst & reg_write;
    assign instr_done = ~rst & done;
    assign illegal    = (state_q == StError);
    assign state      = state_q;

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
`ifdef MC_SLT_EN
                    3'b010:  ALUControl = 3'b101;
`endif
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I core. It replaces the single-cycle main/ALU decoder pair and splits each instruction into fetch, decode, execute, memory and writeback cycles over one shared ALU and one shared memory port. It drives every datapath select and enable, and stalls on a memory-ready handshake. It sits between the instruction register, the ALU flags and the memory interface.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- op  input  7  opcode from the instruction register
- funct3  input  3  from the instruction register
- funct7  input  7  from the instruction register; only bit 5 is used
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = Imm, 10 = constant 4
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal  output  1  sticky illegal-opcode flag
- state  output  4  current state encoding, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, ERROR 11.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PC update are both equal to mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD when op=0000011, otherwise to MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held high until mem_ready=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PC update=1, then ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then FETCH.
- ERROR: all enables 0, illegal=1. The FSM stays in ERROR until rst.
- PCWrite = PC update | (Branch & zero).
- ImmSrc is decoded combinationally from op:
  - 0000011 or 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other op → 00
- ALUControl:
  - ALUOp 00 → 000
  - ALUOp 01 → 001
  - ALUOp 10, decoded by funct3:
    - 000 → 001 when op[5]&funct7[5] (sub), otherwise 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - any other funct3 → 000
- instr_done is high in:
  - MEMWB
  - ALUWB
  - BEQ
  - MEMWRITE when mem_ready=1
- All selects and enables not listed for a state are 0.

## Timing
- Outputs are Moore style, except the FETCH/MEMWRITE mem_ready gating and PCWrite's zero term, which are combinational.
- While rst=1:
  - state = FETCH
  - illegal = 0
  - PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0
  - selects take their FETCH values
- First fetch begins in the first cycle after rst deasserts.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type ALU: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Asserting rst mid-instruction aborts the instruction immediately. No write enable is asserted during reset.

## Configuration
- MC_SLT_EN:
  - Defined: funct3=010 under ALUOp 10 yields ALUControl=101.
  - Undefined: that funct3 yields 000 (add), and slt/slti execute as add.

## Test plan
- Reset → state=0, illegal=0, all enables 0; after release with mem_ready=1 → IRWrite=1 and PCWrite=1 in cycle 1.
- add (op 0110011, funct3 000, funct7 0000000), mem_ready=1 → states 0,1,6,7,0; ALUControl=000 in state 6; RegWrite=1 only in state 7.
- sub (funct7 0100000) → ALUControl=001 in state 6.
- lw with mem_ready low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; RegWrite=1 with ResultSrc=01 in state 4.
- sw with mem_ready=0 for 3 cycles → MemWrite held high for 4 cycles; instr_done pulses once.
- beq with zero=1 → PCWrite=1 in state 10; with zero=0 → PCWrite=0.
- op 1111111 → ERROR (state=11), illegal=1 persists until rst, and no enables are asserted.
